aes_msg_packer: RTL

AES_MSG_PACKER -- requirements
Module: aes_msg_packer

---
 rtl/aes_msg_packer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/aes_msg_packer.sv
// aes_msg_packer: gathers a 32-byte frame (16 plaintext bytes, then 16 key bytes)
// and emits it as four big-endian {plaintext, key} word pairs to an AES core.
module aes_msg_packer #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid_in,
  output logic                  byte_ready_out,
  output logic [DATA_WIDTH-1:0] plaintext_out,
  output logic [DATA_WIDTH-1:0] key_out,
  output logic                  MP_dv_out,
  output logic                  err_timeout_out
);

  localparam int                IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_stateNext;
  logic [4:0]            r_byteCnt;
  logic [4:0]            w_byteCntNext;
  logic [IDLE_W-1:0]     r_idleCnt;
  logic [IDLE_W-1:0]     w_idleCntNext;
  logic [1:0]            r_beat;
  logic [1:0]            w_beatNext;
  logic [127:0]          r_ptBuf;
  logic [127:0]          w_ptBufNext;
  logic [127:0]          r_keyBuf;
  logic [127:0]          w_keyBufNext;
  logic                  r_ready;
  logic                  r_dv;
  logic                  w_dvNext;
  logic                  r_err;
  logic                  w_errNext;
  logic [DATA_WIDTH-1:0] r_ptOut;
  logic [DATA_WIDTH-1:0] w_ptOutNext;
  logic [DATA_WIDTH-1:0] r_keyOut;
  logic [DATA_WIDTH-1:0] w_keyOutNext;
  logic                  w_accept;

  assign w_accept = byte_valid_in && r_ready;

  // Buffers shift left by a byte while collecting, so byte 0 lands in the top
  // byte of word 0; during EMIT they shift by a word so the top word is always next.
  always_comb begin
    w_stateNext   = r_state;
    w_byteCntNext = r_byteCnt;
    w_idleCntNext = r_idleCnt;
    w_beatNext    = r_beat;
    w_ptBufNext   = r_ptBuf;
    w_keyBufNext  = r_keyBuf;
    w_dvNext      = 1'b0;
    w_errNext     = 1'b0;
    w_ptOutNext   = '0;
    w_keyOutNext  = '0;
    case (r_state)
      COLLECT: begin
        if (w_accept) begin
          w_idleCntNext = '0;
          if (!r_byteCnt[4]) begin
            w_ptBufNext = {r_ptBuf[119:0], byte_in};
          end else begin
            w_keyBufNext = {r_keyBuf[119:0], byte_in};
          end
          if (r_byteCnt == 5'd31) begin
            w_stateNext   = EMIT;
            w_byteCntNext = '0;
            w_beatNext    = '0;
            w_dvNext      = 1'b1;
            w_ptOutNext   = w_ptBufNext[127:96];
            w_keyOutNext  = w_keyBufNext[127:96];
          end else begin
            w_byteCntNext = r_byteCnt + 5'd1;
          end
        end else if (r_byteCnt != 5'd0) begin
          // An accepted byte always takes priority over an expiring idle count.
          if (r_idleCnt == IDLE_LAST) begin
            w_byteCntNext = '0;
            w_idleCntNext = '0;
            w_ptBufNext   = '0;
            w_keyBufNext  = '0;
            w_errNext     = 1'b1;
          end else begin
            w_idleCntNext = r_idleCnt + IDLE_W'(1);
          end
        end
      end
      EMIT: begin
        if (r_beat == 2'd3) begin
          w_stateNext  = COLLECT;
          w_beatNext   = '0;
          w_ptBufNext  = '0;
          w_keyBufNext = '0;
        end else begin
          w_beatNext   = r_beat + 2'd1;
          w_ptBufNext  = {r_ptBuf[95:0], 32'h0};
          w_keyBufNext = {r_keyBuf[95:0], 32'h0};
          w_dvNext     = 1'b1;
          w_ptOutNext  = w_ptBufNext[127:96];
          w_keyOutNext = w_keyBufNext[127:96];
        end
      end
      default: begin
        w_stateNext = COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= COLLECT;
      r_byteCnt <= '0;
      r_idleCnt <= '0;
      r_beat    <= '0;
      r_ptBuf   <= '0;
      r_keyBuf  <= '0;
      r_ready   <= 1'b1;
      r_dv      <= 1'b0;
      r_err     <= 1'b0;
      r_ptOut   <= '0;
      r_keyOut  <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_byteCnt <= w_byteCntNext;
      r_idleCnt <= w_idleCntNext;
      r_beat    <= w_beatNext;
      r_ptBuf   <= w_ptBufNext;
      r_keyBuf  <= w_keyBufNext;
      r_ready   <= (w_stateNext == COLLECT);
      r_dv      <= w_dvNext;
      r_err     <= w_errNext;
      r_ptOut   <= w_ptOutNext;
      r_keyOut  <= w_keyOutNext;
    end
  end

  assign byte_ready_out  = r_ready;
  assign MP_dv_out       = r_dv;
  assign plaintext_out   = r_ptOut;
  assign key_out         = r_keyOut;
  assign err_timeout_out = r_err;

endmodule
